// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding the accumulator: single-cycle logic/arith ops
// plus iterative shift-add multiply and restoring divide/modulo.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_DIV = 4'h9;
    localparam logic [3:0] OP_MOD = 4'hA;
    localparam logic [3:0] OP_PSB = 4'hB;

    logic [1:0]       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi, lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [3:0]       sh;
    logic [WIDTH-1:0] s_res;
    logic             s_c, s_v;

    always_comb begin
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};
        sh    = b[3:0];
        // Extra bit catches the last bit shifted out; zero for a shift of 0.
        shl_w = {1'b0, a} << sh;
        shr_w = {a, 1'b0} >> sh;
        s_res = a;
        s_c   = 1'b0;
        s_v   = 1'b0;
        case (op)
            OP_ADD: begin
                s_res = add_w[WIDTH-1:0];
                s_c   = add_w[WIDTH];
                s_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                        (s_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = sub_w[WIDTH-1:0];
                s_c   = sub_w[WIDTH];
                s_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                        (s_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: s_res = a & b;
            OP_OR:  s_res = a | b;
            OP_XOR: s_res = a ^ b;
            OP_NOT: s_res = ~a;
            OP_SHL: begin
                s_res = shl_w[WIDTH-1:0];
                s_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                s_res = shr_w[WIDTH:1];
                s_c   = shr_w[0];
            end
            OP_PSB: s_res = b;
            default: s_res = a;
        endcase
    end

    logic [WIDTH:0]   m_sum;
    logic [WIDTH:0]   d_sh;
    logic [WIDTH+1:0] d_trial;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH-1:0] f_res;
    logic             f_c;

    // MUL: hi:lo is the product register, lo starts as the multiplier.
    // DIV: hi is the partial remainder, lo shifts dividend out/quotient in.
    always_comb begin
        m_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
        d_sh    = {hi, lo[WIDTH-1]};
        d_trial = {1'b0, d_sh} - {2'b00, b_q};
        if (state == S_MUL) begin
            {hi_n, lo_n} = {m_sum, lo[WIDTH-1:1]};
        end else if (!d_trial[WIDTH+1]) begin
            hi_n = d_trial[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = d_sh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], 1'b0};
        end
        f_res = lo_n;
        f_c   = 1'b0;
        if (state == S_MUL) begin
            f_c = |hi_n;
        end else begin
            f_c = (b_q == '0);
            if (op_q == OP_MOD) f_res = hi_n;
        end
    end

    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;

    always_comb begin
        w_res = (state == S_IDLE) ? s_res : f_res;
        w_c   = (state == S_IDLE) ? s_c : f_c;
        w_v   = (state == S_IDLE) ? s_v : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        cnt  <= '0;
                        hi   <= '0;
                        if (op == OP_MUL) begin
                            lo    <= b;
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else if (op == OP_DIV || op == OP_MOD) begin
                            lo    <= a;
                            busy  <= 1'b1;
                            state <= S_DIV;
                        end else begin
                            result <= w_res;
                            flag_z <= (w_res == '0);
                            flag_n <= w_res[WIDTH-1];
                            flag_c <= w_c;
                            flag_v <= w_v;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result <= w_res;
                        flag_z <= (w_res == '0);
                        flag_n <= w_res[WIDTH-1];
                        flag_c <= w_c;
                        flag_v <= w_v;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
